hdlc_bit_serializer: RTL and testbench
======================================

# hdlc_bit_serializer

Parametrised parallel-to-serial bit engine for the slow-control HDLC transmit path. It replaces the fixed 8:1 select-and-hold output stage. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock. Its internal counters select bits and insert HDLC zero-stuffing bits after five consecutive data ones. A per-word raw flag passes flag/abort patterns (e.g. 0x7E) unstuffed.

## Interface
- WIDTH, 8: bits per loaded word; legal range 2..32.
- LSB_FIRST, 1: 1 = bit 0 emitted first; 0 = bit WIDTH-1 first.
- STUFF_EN, 1: 1 = zero-insertion active for non-raw words; 0 = never stuff.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- data_in  in  WIDTH  word to serialize.
- raw_in  in  1  qualifies data_in as raw: no stuffing, no ones counting.
- load_valid  in  1  word offered.
- load_ready  out  1  engine can accept a word this cycle.
- dout  out  1  registered serial bit.
- dout_valid  out  1  dout carries a data or stuff bit this cycle.
- stuff_active  out  1  current dout is an inserted stuff 0.
- busy  out  1  a word is in flight, including a pending stuff bit.

## Operation
- States: IDLE, SHIFT, STUFF.
- Registers: word shift register, bit_cnt (0..WIDTH-1), ones_cnt (0..5), raw_q.
- Accept occurs on an edge where load_valid && load_ready. It captures data_in and raw_q, sets bit_cnt=0 and enters SHIFT. Bit 0 of the emission order appears on dout after that edge.
- SHIFT:
  - Each edge presents the next data bit.
  - Non-raw with STUFF_EN=1: a 1 bit increments ones_cnt; a 0 bit clears it.
  - When a presented 1 makes ones_cnt = 5, the next edge enters STUFF instead of advancing.
- STUFF:
  - Presents dout=0 with stuff_active=1 for exactly one cycle and clears ones_cnt.
  - Then resumes SHIFT at the held bit position, or ends the word.
- ones_cnt persists across words and idle gaps. It is cleared only by:
  - rst;
  - a non-raw 0 data bit;
  - a stuff bit;
  - completion of a raw word.
- Raw words:
  - ones_cnt is not updated during the word.
  - No stuffing is applied.
  - ones_cnt is forced to 0 when the last raw bit is presented.
- End of word:
  - With no accept, the next edge enters IDLE: dout=0, dout_valid=0, busy=0.
  - With an accept, bit 0 of the new word follows with no gap.
- load_ready is combinational from registered state. It is 1 when:
  - in IDLE; or
  - the current dout is the last data bit and no stuff is pending; or
  - the current dout is the stuff bit following the last data bit.
- load_valid while load_ready=0 is ignored; the source holds data_in, raw_in and load_valid.
- Reset mid-word discards the word. There is no partial-word recovery.

## Timing
- Reset values:
  - dout=0, dout_valid=0, stuff_active=0, busy=0, load_ready=1 (combinational, IDLE).
  - Internal: ones_cnt=0, bit_cnt=0, state IDLE.
- Latency: accept edge to first dout_valid bit is 1 clock.
- Non-raw word: occupies WIDTH + (number of stuff bits) consecutive dout_valid cycles.
- Raw word: exactly WIDTH cycles.
- Throughput: continuous streaming with back-to-back accepts; dout_valid never drops between words.
- A stuff bit triggered by the last data bit delays the next word's bit 0 by exactly one cycle.
- Simultaneous rst and load_valid: rst wins; nothing is accepted.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> dout, dout_valid, stuff_active and busy go 0 without a clock edge; load_ready=1 after release.
- WIDTH=8, LSB_FIRST=1, load 0x3C non-raw -> dout 0,0,1,1,1,1,0,0 over 8 cycles; stuff_active never 1; load_ready=1 on the 8th bit.
- Load 0xFF non-raw -> 9 cycles: 1,1,1,1,1,0,1,1,1. stuff_active=1 only on the 6th cycle; ones_cnt=3 at end.
- Back-to-back 0xE0 then 0x03 non-raw -> 0,0,0,0,0,1,1,1 | 1,1,0(stuff),0,0,0,0,0,0. Stuffing crosses the word boundary; 17 contiguous valid cycles.
- Raw 0x7E then non-raw 0x1F -> 0,1,1,1,1,1,1,0 unstuffed, then 1,1,1,1,1,0(stuff),0,0,0. Shows counter clear after the raw word; 17 contiguous cycles.
- LSB_FIRST=0, WIDTH=12, STUFF_EN=0, load 0xFFF -> 12 ones, no stuff bits.
- rst during bit 3 of a word, then load 0x01 -> fresh sequence 1,0,0,0,0,0,0,0; no residual stuffing.

Source files
------------

// File: rtl/hdlc_bit_serializer.sv
// HDLC transmit bit engine: parallel word in, one bit per clock out,
// with zero insertion after five consecutive data ones.
module hdlc_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit STUFF_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             raw_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             stuff_active,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] STUFF = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [2:0]       ones_cnt;
    logic             raw_q;

    logic             last_bit;
    logic             stuff_pend;
    logic             accept;
    logic             advance;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] next_rest;

    function automatic logic [2:0] ones_next(input logic [2:0] cur,
                                             input logic b);
        if (!STUFF_EN)
            return 3'd0;
        return b ? cur + 3'd1 : 3'd0;
    endfunction

    assign last_bit   = (bit_cnt == LAST);
    // A stuff is owed only right after the fifth counted one was presented
    assign stuff_pend = STUFF_EN && (state == SHIFT) && !raw_q
                        && (ones_cnt == 3'd5);

    assign load_ready = (state == IDLE)
                      || ((state == SHIFT) && last_bit && !stuff_pend)
                      || ((state == STUFF) && last_bit);

    assign accept  = load_valid && load_ready;
    assign advance = ((state == SHIFT) && !stuff_pend && !last_bit)
                   || ((state == STUFF) && !last_bit);

    assign first_bit = LSB_FIRST ? data_in[0] : data_in[WIDTH-1];
    assign load_rest = LSB_FIRST ? (data_in >> 1) : (data_in << 1);
    assign next_bit  = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
    assign next_rest = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

    assign dout_valid   = (state != IDLE);
    assign busy         = (state != IDLE);
    assign stuff_active = (state == STUFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            ones_cnt <= 3'd0;
            raw_q    <= 1'b0;
            dout     <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            dout    <= first_bit;
            sreg    <= load_rest;
            bit_cnt <= '0;
            raw_q   <= raw_in;
            if (!raw_in)
                ones_cnt <= ones_next(ones_cnt, first_bit);
        end else if (stuff_pend) begin
            state    <= STUFF;
            dout     <= 1'b0;
            ones_cnt <= 3'd0;
        end else if (advance) begin
            state   <= SHIFT;
            dout    <= next_bit;
            sreg    <= next_rest;
            bit_cnt <= bit_cnt + 1'b1;
            // Raw words leave the counter alone until their last bit
            if (raw_q) begin
                if ((bit_cnt + 1'b1) == LAST)
                    ones_cnt <= 3'd0;
            end else begin
                ones_cnt <= ones_next(ones_cnt, next_bit);
            end
        end else begin
            state   <= IDLE;
            dout    <= 1'b0;
            bit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hdlc_bit_serializer.sv
// Bench for hdlc_bit_serializer: directed and random words checked
// against a queue-based model of the stuffed bit stream.
module tb_hdlc_bit_serializer;

    typedef struct {
        bit b;
        bit s;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        raw_in;
    logic        load_valid;
    logic        load_ready;
    logic        dout;
    logic        dout_valid;
    logic        stuff_active;
    logic        busy;

    logic [11:0] d2;
    logic        lv2;
    logic        ready2;
    logic        dout2;
    logic        valid2;
    logic        stuff2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    ent_t expq[$];
    int m_ones = 0;
    bit last_acc;

    always #5 clk = ~clk;

    hdlc_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .STUFF_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .raw_in(raw_in),
        .load_valid(load_valid), .load_ready(load_ready), .dout(dout),
        .dout_valid(dout_valid), .stuff_active(stuff_active), .busy(busy)
    );

    hdlc_bit_serializer #(.WIDTH(12), .LSB_FIRST(1'b0), .STUFF_EN(1'b0)) dut12 (
        .clk(clk), .rst(rst), .data_in(d2), .raw_in(1'b0),
        .load_valid(lv2), .load_ready(ready2), .dout(dout2),
        .dout_valid(valid2), .stuff_active(stuff2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits for one word: data bits, plus a 0 after five ones
    task automatic model_push(input logic [7:0] w, input logic r);
        bit b;
        for (int i = 0; i < 8; i++) begin
            b = w[i];
            expq.push_back('{b, 1'b0});
            if (!r) begin
                if (b) m_ones++;
                else m_ones = 0;
                if (m_ones == 5) begin
                    expq.push_back('{1'b0, 1'b1});
                    m_ones = 0;
                end
            end
        end
        if (r) m_ones = 0;
    endtask

    task automatic step();
        bit acc;
        ent_t e;
        chk("load_ready", load_ready, expq.size() == 0);
        acc = load_valid && load_ready;
        if (acc) model_push(data_in, raw_in);
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("dout_valid", dout_valid, 1);
            chk("busy", busy, 1);
            chk("dout", dout, e.b);
            chk("stuff_active", stuff_active, e.s);
        end else begin
            chk("idle_valid", dout_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_dout", dout, 0);
            chk("idle_stuff", stuff_active, 0);
        end
        last_acc = acc;
    endtask

    task automatic offer(input logic [7:0] w, input logic r);
        int k;
        load_valid = 1'b1;
        data_in = w;
        raw_in = r;
        last_acc = 1'b0;
        k = 0;
        while (!last_acc && k < 40) begin
            step();
            k++;
        end
        if (!last_acc) begin
            errors++;
            $display("FAIL offer_timeout: word %0h not accepted", w);
        end
    endtask

    task automatic drain(input int n);
        load_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [11:0] w12;
        logic [11:0] words12 [2];
        rst = 1'b1;
        load_valid = 1'b0;
        data_in = '0;
        raw_in = 1'b0;
        lv2 = 1'b0;
        d2 = '0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_stuff", stuff_active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        offer(8'h3C, 1'b0);
        drain(2);
        offer(8'hFF, 1'b0);
        drain(2);
        offer(8'hE0, 1'b0);
        offer(8'h03, 1'b0);
        drain(3);
        offer(8'h7E, 1'b1);
        offer(8'h1F, 1'b0);
        drain(3);

        // Asynchronous reset in the middle of a word with four ones counted
        offer(8'hFF, 1'b0);
        drain(3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_dout", dout, 0);
        chk("async_valid", dout_valid, 0);
        chk("async_stuff", stuff_active, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", load_ready, 1);
        expq.delete();
        m_ones = 0;
        load_valid = 1'b1;
        data_in = 8'h55;
        @(posedge clk);
        #1;
        chk("rst_wins", dout_valid, 0);
        load_valid = 1'b0;
        rst = 1'b0;
        step();
        offer(8'h01, 1'b0);
        drain(10);

        for (int n = 0; n < 80; n++) begin
            offer(8'($urandom | $urandom), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0)
                drain($urandom_range(0, 3));
        end
        drain(12);

        words12[0] = 12'hFFF;
        words12[1] = 12'hA05;
        for (int j = 0; j < 2; j++) begin
            w12 = words12[j];
            d2 = w12;
            lv2 = 1'b1;
            chk("w12_ready", ready2, 1);
            @(posedge clk);
            #1;
            lv2 = 1'b0;
            for (int i = 0; i < 12; i++) begin
                chk("w12_dout", dout2, w12[11-i]);
                chk("w12_valid", valid2, 1);
                chk("w12_stuff", stuff2, 0);
                if (i == 11)
                    chk("w12_last_ready", ready2, 1);
                @(posedge clk);
                #1;
            end
            chk("w12_end", valid2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
